// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: block codes, grid geometry and line_clearer states.
package tetris_pkg;

    // Cell contents stored in grid memory
    localparam logic [7:0] BLOCK_AIR    = 8'd0;
    localparam logic [7:0] BLOCK_I      = 8'd1;
    localparam logic [7:0] BLOCK_O      = 8'd2;
    localparam logic [7:0] BLOCK_T      = 8'd3;
    localparam logic [7:0] BLOCK_S      = 8'd4;
    localparam logic [7:0] BLOCK_Z      = 8'd5;
    localparam logic [7:0] BLOCK_J      = 8'd6;
    localparam logic [7:0] BLOCK_L      = 8'd7;
    localparam logic [7:0] BLOCK_BORDER = 8'd8;

    // Grid geometry: 20 rows x 12 columns, followed by the piece placement area
    localparam logic [7:0] GRID_START_ADDR       = 8'd0;
    localparam logic [7:0] GRID_END_ADDR         = 8'd239;
    localparam logic [7:0] PLACE_AREA_START_ADDR = 8'd240;
    localparam logic [7:0] PLACE_AREA_END_ADDR   = 8'd251;
    localparam int         GRID_COLS             = 12;
    localparam int         GRID_ROWS             = 20;
    localparam int         FIRST_COL             = 1;
    localparam int         LAST_COL              = 10;

    // line_clearer FSM states
    typedef enum logic [2:0] {
        LC_IDLE,
        LC_CHK_ADDR,
        LC_CHK_DATA,
        LC_CPY_RD,
        LC_CPY_CAP,
        LC_CPY_WR,
        LC_CLR_WR,
        LC_DONE
    } lc_state_t;

endpackage

// File: rtl/line_clearer.sv
// Line-clear engine: scans the grid bottom-up, removes full rows by shifting
// the stack above them down one row, and counts the rows removed.
module line_clearer
    import tetris_pkg::*;
#(
    parameter int GRID_COLS = 12,
    parameter int GRID_ROWS = 20,
    parameter int FIRST_COL = 1,
    parameter int LAST_COL  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tetris_grid_in,
    output logic [7:0] grid_address,
    output logic [7:0] grid_data_out,
    output logic       write_en,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared
);

    localparam logic [4:0] BOTTOM_ROW = 5'(GRID_ROWS - 1);
    localparam logic [3:0] COL_FIRST  = 4'(FIRST_COL);
    localparam logic [3:0] COL_LAST   = 4'(LAST_COL);

    lc_state_t  state, state_nxt;
    logic [4:0] row, row_nxt;
    logic [4:0] dst, dst_nxt;
    logic [3:0] col, col_nxt;
    logic [7:0] cpy_buf, cpy_buf_nxt;
    logic [4:0] lines_nxt;
    logic       cell_air;

    // Start address of a row; the 12-wide grid uses a shift-add instead of a multiplier
    function automatic logic [7:0] row_base(input logic [4:0] r);
        if (GRID_COLS == 12)
            row_base = ({3'b0, r} << 3) + ({3'b0, r} << 2);
        else
            row_base = 8'({3'b0, r} * GRID_COLS);
    endfunction

    assign cell_air = (tetris_grid_in[3:0] == BLOCK_AIR[3:0]);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LC_IDLE;
            row           <= '0;
            col           <= '0;
            dst           <= '0;
            cpy_buf       <= '0;
            lines_cleared <= '0;
        end else begin
            state         <= state_nxt;
            row           <= row_nxt;
            col           <= col_nxt;
            dst           <= dst_nxt;
            cpy_buf       <= cpy_buf_nxt;
            lines_cleared <= lines_nxt;
        end
    end

    // Next-state, register updates and memory-side outputs (outputs depend on registers only)
    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        col_nxt       = col;
        dst_nxt       = dst;
        cpy_buf_nxt   = cpy_buf;
        lines_nxt     = lines_cleared;
        grid_address  = '0;
        grid_data_out = '0;
        write_en      = 1'b0;
        busy          = (state != LC_IDLE) && (state != LC_DONE);
        done          = 1'b0;
        case (state)
            LC_IDLE: begin
                if (start) begin
                    row_nxt   = BOTTOM_ROW;
                    col_nxt   = COL_FIRST;
                    lines_nxt = '0;
                    state_nxt = LC_CHK_ADDR;
                end
            end
            LC_CHK_ADDR: begin
                grid_address = row_base(row) + {4'b0, col};
                state_nxt    = LC_CHK_DATA;
            end
            LC_CHK_DATA: begin
                grid_address = row_base(row) + {4'b0, col};
                if (cell_air) begin
                    if (row == 5'd0) begin
                        state_nxt = LC_DONE;
                    end else begin
                        row_nxt   = row - 5'd1;
                        col_nxt   = COL_FIRST;
                        state_nxt = LC_CHK_ADDR;
                    end
                end else if (col < COL_LAST) begin
                    col_nxt   = col + 4'd1;
                    state_nxt = LC_CHK_ADDR;
                end else begin
                    if (lines_cleared != 5'd31) lines_nxt = lines_cleared + 5'd1;
                    dst_nxt   = row;
                    col_nxt   = COL_FIRST;
                    state_nxt = (row == 5'd0) ? LC_CLR_WR : LC_CPY_RD;
                end
            end
            LC_CPY_RD: begin
                grid_address = row_base(dst - 5'd1) + {4'b0, col};
                state_nxt    = LC_CPY_CAP;
            end
            LC_CPY_CAP: begin
                grid_address = row_base(dst - 5'd1) + {4'b0, col};
                cpy_buf_nxt  = tetris_grid_in;
                state_nxt    = LC_CPY_WR;
            end
            LC_CPY_WR: begin
                write_en      = 1'b1;
                grid_address  = row_base(dst) + {4'b0, col};
                grid_data_out = cpy_buf;
                if (col < COL_LAST) begin
                    col_nxt   = col + 4'd1;
                    state_nxt = LC_CPY_RD;
                end else begin
                    col_nxt   = COL_FIRST;
                    dst_nxt   = dst - 5'd1;
                    state_nxt = (dst == 5'd1) ? LC_CLR_WR : LC_CPY_RD;
                end
            end
            LC_CLR_WR: begin
                write_en      = 1'b1;
                grid_address  = {4'b0, col};
                grid_data_out = BLOCK_AIR;
                if (col < COL_LAST) begin
                    col_nxt = col + 4'd1;
                end else begin
                    // Rescan the same row: the row above has dropped into it
                    col_nxt   = COL_FIRST;
                    state_nxt = LC_CHK_ADDR;
                end
            end
            LC_DONE: begin
                done      = 1'b1;
                state_nxt = LC_IDLE;
            end
            default: state_nxt = LC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_clearer.sv
// Self-checking bench for line_clearer: synchronous grid memory, directed
// cases plus random grids against a row-compaction reference model.
module tb_line_clearer;
    import tetris_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tetris_grid_in;
    logic [7:0] grid_address;
    logic [7:0] grid_data_out;
    logic       write_en;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;

    always #5 clk = ~clk;

    line_clearer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .tetris_grid_in(tetris_grid_in),
        .grid_address  (grid_address),
        .grid_data_out (grid_data_out),
        .write_en      (write_en),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    // Grid memory with a staging copy loaded in one cycle
    logic [7:0]  mem   [0:251];
    logic [7:0]  stage [0:251];
    logic        load = 1'b0;
    logic [7:0]  rd_q;
    logic [15:0] wr_q[$];
    int          border_bad = 0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 252; i++) mem[i] <= stage[i];
        end else if (write_en) begin
            mem[grid_address] <= grid_data_out;
            wr_q.push_back({grid_address, grid_data_out});
            if ((grid_address % 12) == 0 || (grid_address % 12) == 11) border_bad <= border_bad + 1;
        end
        rd_q <= mem[grid_address];
    end
    assign tetris_grid_in = rd_q;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: drop full rows, keep the rest in order, pad with air at the top
    logic [7:0] ref_in  [0:239];
    logic [7:0] ref_out [0:239];
    int         ref_lines;

    task automatic ref_model();
        int kept[$];
        ref_lines = 0;
        for (int r = 19; r >= 0; r--) begin
            bit full = 1'b1;
            for (int c = 1; c <= 10; c++)
                if (ref_in[r*12+c][3:0] == 4'd0) full = 1'b0;
            if (full) ref_lines++;
            else kept.push_back(r);
        end
        if (ref_lines > 31) ref_lines = 31;
        for (int i = 0; i < 240; i++) ref_out[i] = ref_in[i];
        for (int r = 19; r >= 0; r--) begin
            int k = 19 - r;
            for (int c = 1; c <= 10; c++)
                ref_out[r*12+c] = (k < kept.size()) ? ref_in[kept[k]*12+c] : 8'd0;
        end
    endtask

    task automatic clear_grid();
        for (int i = 0; i < 252; i++) stage[i] = BLOCK_AIR;
        for (int r = 0; r < 20; r++) begin
            stage[r*12]    = BLOCK_BORDER;
            stage[r*12+11] = BLOCK_BORDER;
        end
    endtask

    task automatic fill_row(input int r, input logic [7:0] v);
        for (int c = 1; c <= 10; c++) stage[r*12+c] = v;
    endtask

    task automatic load_grid();
        for (int i = 0; i < 240; i++) ref_in[i] = stage[i];
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        ref_model();
    endtask

    // Pulse start, count cycles to done; optionally re-pulse start while busy
    task automatic run(input bit repulse, output int cyc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (cyc < 20000) begin
            #1;
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (done) break;
            start = repulse && (cyc == 5 || cyc == 23);
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic check_result(input string tag, input int bb0);
        int   errs = 0;
        int   first = -1;
        chk({tag, "_lines"}, lines_cleared, ref_lines);
        for (int i = 0; i < 240; i++)
            if (mem[i] !== ref_out[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        if (errs != 0) $display("  %s first differing address %0d: got=%0d expected=%0d", tag, first, mem[first], ref_out[first]);
        chk({tag, "_mem_diffs"}, errs, 0);
        chk({tag, "_border_writes"}, border_bad - bb0, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"},  grid_address, 0);
        chk({tag, "_data"},  grid_data_out, 0);
        chk({tag, "_we"},    write_en, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_lines"}, lines_cleared, 0);
    endtask

    initial begin
        int cyc, cyc1, wb, bb, nwr;
        logic [15:0] w;

        #12;
        chk_outputs_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Empty grid
        clear_grid();
        load_grid();
        wb = wr_q.size(); bb = border_bad;
        run(1'b0, cyc);
        chk("empty_cycles", cyc, 41);
        chk("empty_writes", wr_q.size() - wb, 0);
        check_result("empty", bb);

        // Bottom row full, one block above it
        clear_grid();
        fill_row(19, BLOCK_I);
        stage[217] = BLOCK_T;
        load_grid();
        bb = border_bad;
        run(1'b0, cyc);
        chk("one_addr229", mem[229], 3);
        nwr = 0;
        for (int a = 230; a <= 238; a++) if (mem[a] != 8'd0) nwr++;
        chk("one_row19_rest_air", nwr, 0);
        nwr = 0;
        for (int a = 217; a <= 226; a++) if (mem[a] != 8'd0) nwr++;
        chk("one_row18_air", nwr, 0);
        check_result("one", bb);

        // Two bottom rows full
        clear_grid();
        fill_row(18, BLOCK_O);
        fill_row(19, BLOCK_S);
        stage[205] = BLOCK_Z;
        load_grid();
        bb = border_bad;
        run(1'b0, cyc);
        chk("two_addr229", mem[229], 5);
        check_result("two", bb);

        // Only the top row full
        clear_grid();
        fill_row(0, BLOCK_L);
        load_grid();
        wb = wr_q.size(); bb = border_bad;
        run(1'b0, cyc);
        chk("top_write_count", wr_q.size() - wb, 10);
        for (int i = 0; i < 10 && wb + i < wr_q.size(); i++) begin
            w = wr_q[wb+i];
            chk("top_write_addr", w[15:8], i + 1);
            chk("top_write_data", w[7:0], 0);
        end
        check_result("top", bb);

        // Re-pulsed start while busy: same cycles and result as a single pulse
        clear_grid();
        fill_row(19, BLOCK_J);
        fill_row(17, BLOCK_I);
        stage[190] = BLOCK_T;
        stage[161] = 8'h30;
        stage[175] = BLOCK_O;
        load_grid();
        run(1'b0, cyc1);
        load_grid();
        bb = border_bad;
        run(1'b1, cyc);
        chk("repulse_cycles", cyc, cyc1);
        check_result("repulse", bb);

        // Reset during a copy write, then a clean rerun on the partial grid
        clear_grid();
        fill_row(19, BLOCK_I);
        stage[217] = BLOCK_T;
        stage[222] = BLOCK_L;
        load_grid();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        nwr = 0;
        cyc = 0;
        while (nwr < 4 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (write_en) nwr++;
        end
        chk("rst_reached_cpy_wr", nwr, 4);
        reset = 1'b1;
        #1;
        chk_outputs_zero("rst_mid");
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 240; i++) ref_in[i] = mem[i];
        ref_model();
        bb = border_bad;
        run(1'b0, cyc);
        check_result("after_reset", bb);

        // Random grids
        for (int t = 0; t < 8; t++) begin
            clear_grid();
            for (int r = 0; r < 20; r++) begin
                if ($urandom_range(0, 99) < 35) begin
                    for (int c = 1; c <= 10; c++) stage[r*12+c] = 8'($urandom_range(1, 7));
                end else if ($urandom_range(0, 99) < 50) begin
                    int hole = $urandom_range(1, 10);
                    for (int c = 1; c <= 10; c++)
                        if (c == hole) stage[r*12+c] = ($urandom_range(0, 1) != 0) ? 8'h30 : 8'h00;
                        else if ($urandom_range(0, 99) < 30) stage[r*12+c] = 8'h00;
                        else stage[r*12+c] = 8'($urandom_range(1, 7));
                end
            end
            load_grid();
            bb = border_bad;
            run(1'b0, cyc);
            check_result("rand", bb);
        end

        chk("border_228", mem[228], 8);
        chk("border_239", mem[239], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_clearer.md
# line_clearer

Line-clear engine downstream of the grid controller. Once the active piece locks, the grid controller pulses `start` and passes grid-memory ownership to this block. It scans the 20×12 play grid bottom-up, deletes every full row, shifts the stack above it down by one row, and reports how many lines it removed. It then returns memory ownership with a one-cycle `done` pulse.

## Interface
Parameters:
- `GRID_COLS`, 12: cells per row; address = row*12 + col.
- `GRID_ROWS`, 20: rows 0 (top) to 19 (bottom); addresses 0–239.
- `FIRST_COL`, 1: first playable column; column 0 is border.
- `LAST_COL`, 10: last playable column; column 11 is border.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle request to begin a scan. Sampled only in IDLE.
- `tetris_grid_in`, input, 8: grid memory read data, valid the cycle after the address.
- `grid_address`, output, 8: grid memory address.
- `grid_data_out`, output, 8: grid memory write data.
- `write_en`, output, 1: grid memory write strobe.
- `busy`, output, 1: high from the cycle after `start` is accepted until DONE. While high, this block owns memory.
- `done`, output, 1: one-cycle completion pulse.
- `lines_cleared`, output, 5: number of full rows removed in the last scan. Held until the next `start`.

## Operation
- Reset (asynchronous) sets state to IDLE and drives every output to 0: `grid_address`, `grid_data_out`, `write_en`, `busy`, `done`, `lines_cleared`. Internal row, col, dst and buffer registers are also 0.
- Full row: `tetris_grid_in[3:0] != 0` (not air) at every column from 1 to 10. Border columns 0 and 11 are never read or written.
- IDLE: on `start`=1, set row=19, col=1, `lines_cleared`=0, `busy`=1, and go to CHK_ADDR.
- CHK_ADDR: drive `grid_address` = row*12+col, then go to CHK_DATA.
- CHK_DATA: test the returned cell.
  - Cell is air: row is not full. If row==0, go to DONE. Otherwise row−1, col=1, go to CHK_ADDR.
  - Cell is not air and col<10: col+1, go to CHK_ADDR.
  - Cell is not air and col==10: row is full. Increment `lines_cleared` (saturating at 31), set dst=row, col=1. If dst==0, go to CLR_WR; otherwise go to CPY_RD.
- CPY_RD: `grid_address` = (dst−1)*12+col, go to CPY_CAP.
- CPY_CAP: capture `tetris_grid_in` into the buffer, go to CPY_WR.
- CPY_WR: drive `write_en`=1, `grid_address`=dst*12+col, `grid_data_out`=buffer.
  - If col<10: col+1, go to CPY_RD.
  - Otherwise col=1 and dst−1. If the new dst==0, go to CLR_WR; otherwise go to CPY_RD.
- CLR_WR: drive `write_en`=1, `grid_address`=col (row 0), `grid_data_out`=0.
  - If col<10: col+1, stay in CLR_WR.
  - Otherwise col=1 and go to CHK_ADDR with row unchanged. This rescans the same row, because new content has dropped into it.
- DONE: `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- `start` while not in IDLE is ignored.
- Reset mid-operation aborts immediately. Grid contents are left partially shifted; there is no rollback.
- `write_en` is 0 in every state except CPY_WR and CLR_WR.
- `grid_address` and `grid_data_out` are driven only from internal registers; there is no combinational path from `tetris_grid_in` to any output.

## Timing
- Memory reads are synchronous: address in cycle N, data in cycle N+1.
- Check cost is 2 cycles per cell tested. A non-full row aborts at its first air cell.
- Shifting one row costs 30 cycles (3 per cell). Clearing row 0 costs 10 cycles.
- Empty grid: `done` is high 41 cycles after the edge that sampled `start`.
- Worst case, all 20 rows full, is bounded by 20×(20+30×19+10) cycles. The 5-bit `lines_cleared` counter covers 20.

## Structure
- Shared package `tetris_pkg`:
  - Block codes: BLOCK_AIR=0, BLOCK_I..BLOCK_L=1..7, BLOCK_BORDER=8.
  - Grid constants: GRID_START_ADDR=0, GRID_END_ADDR=239, PLACE_AREA_START_ADDR=240, PLACE_AREA_END_ADDR=251, GRID_COLS, GRID_ROWS, FIRST_COL, LAST_COL.
  - State encoding for line_clearer.
- Single module, no sub-module. row*12 is computed as (row<<3)+(row<<2).

## Test plan
- Empty grid with borders (cells at col 0 and col 11 set to 8), pulse `start`:
  - `done` at cycle 41, `lines_cleared`=0.
  - `write_en` never asserted.
- Row 19 (addresses 229–238) filled with code 1, address 217 = 3, all other playable cells air:
  - After `done`, address 229=3 and addresses 230–238=0.
  - Row 18 is all air.
  - `lines_cleared`=1.
- Rows 18 and 19 full, address 205=5:
  - After `done`, address 229=5 and every other playable cell is 0.
  - `lines_cleared`=2.
- Only row 0 full (addresses 1–10):
  - Exactly 10 writes, addresses 1..10 with data 0; no copy writes.
  - `lines_cleared`=1.
- `start` re-pulsed while `busy`:
  - Ignored; result is identical to a single pulse.
- Reset asserted during CPY_WR:
  - All outputs read 0 in the same cycle.
  - A subsequent `start` completes normally.
- Border protection:
  - On every write, address mod 12 is never 0 or 11.
  - Addresses 228 and 239 keep the value 8.
